// File: rtl/fp_mult_driver.sv
// Initiator for the single_multiplier stb/ack operand protocol.
// Queues operand pairs, runs one multiply job at a time, and returns products on a valid/ready port.
module fp_mult_driver #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] job_a,
   input  logic [31:0] job_b,
   input  logic        job_valid,
   output logic        job_ready,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_a_stb,
   output logic        mul_b_stb,
   input  logic        mul_a_ack,
   input  logic        mul_b_ack,
   input  logic [31:0] mul_z,
   input  logic        mul_z_stb,
   output logic        mul_z_ack,
   output logic [31:0] res_z,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        busy,
   output logic        timeout_err,
   output logic [15:0] jobs_done
);

   localparam int unsigned DW   = 32;
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEND   = 2'd1;
   localparam logic [1:0] S_WAIT_Z = 2'd2;
   localparam logic [1:0] S_OUT    = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic            a_stb_q, a_stb_d;
   logic            b_stb_q, b_stb_d;
   logic            z_ack_q, z_ack_d;
   logic [DW-1:0]   res_z_q, res_z_d;
   logic            res_valid_q, res_valid_d;
   logic            tmo_q, tmo_d;
   logic [15:0]     jobs_q, jobs_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [2*DW-1:0] mem_q [DEPTH];

   logic full;
   logic push;
   logic pop;

   assign full      = (count_q == CW'(DEPTH));
   assign push      = job_valid && !full;
   assign job_ready = !full;
   assign busy      = (state_q != S_IDLE) || (count_q != '0);

   assign mul_a       = a_q;
   assign mul_b       = b_q;
   assign mul_a_stb   = a_stb_q;
   assign mul_b_stb   = b_stb_q;
   assign mul_z_ack   = z_ack_q;
   assign res_z       = res_z_q;
   assign res_valid   = res_valid_q;
   assign timeout_err = tmo_q;
   assign jobs_done   = jobs_q;

   // Job FIFO storage; occupancy and pointers live in the state register below.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {job_a, job_b};
   end

   // Next-state: job sequencing, handshakes and watchdog.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      a_stb_d     = a_stb_q;
      b_stb_d     = b_stb_q;
      z_ack_d     = z_ack_q;
      res_z_d     = res_z_q;
      res_valid_d = res_valid_q;
      tmo_d       = tmo_q;
      jobs_d      = jobs_q;
      wd_d        = wd_q;
      pop         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               {a_d, b_d} = mem_q[rd_ptr_q];
               a_stb_d    = 1'b1;
               b_stb_d    = 1'b1;
               pop        = 1'b1;
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            // Operands complete independently; move on once both have been taken.
            if (a_stb_q && mul_a_ack) a_stb_d = 1'b0;
            if (b_stb_q && mul_b_ack) b_stb_d = 1'b0;
            if (!a_stb_d && !b_stb_d) begin
               z_ack_d = 1'b1;
               wd_d    = '0;
               state_d = S_WAIT_Z;
            end
         end
         S_WAIT_Z: begin
            if (mul_z_stb && z_ack_q) begin
               res_z_d     = mul_z;
               res_valid_d = 1'b1;
               z_ack_d     = 1'b0;
               state_d     = S_OUT;
            end else if (TIMEOUT != 0) begin
               wd_d = wd_q + WD_W'(1);
               if (wd_d == WD_W'(TIMEOUT)) begin
                  tmo_d   = 1'b1;
                  z_ack_d = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
         S_OUT: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               jobs_d      = jobs_q + 16'd1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         a_stb_q     <= 1'b0;
         b_stb_q     <= 1'b0;
         z_ack_q     <= 1'b0;
         res_z_q     <= '0;
         res_valid_q <= 1'b0;
         tmo_q       <= 1'b0;
         jobs_q      <= '0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         a_q         <= a_d;
         b_q         <= b_d;
         a_stb_q     <= a_stb_d;
         b_stb_q     <= b_stb_d;
         z_ack_q     <= z_ack_d;
         res_z_q     <= res_z_d;
         res_valid_q <= res_valid_d;
         tmo_q       <= tmo_d;
         jobs_q      <= jobs_d;
         wd_q        <= wd_d;
      end
   end

endmodule

// File: tb/tb_fp_mult_driver.sv
// Bench for fp_mult_driver with a behavioural multiplier responder (programmable ack/z delays).
module tb_fp_mult_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] job_a, job_b;
   logic        job_valid;
   logic        job_ready;
   logic [31:0] mul_a, mul_b;
   logic        mul_a_stb, mul_b_stb;
   logic        mul_a_ack, mul_b_ack;
   logic [31:0] mul_z;
   logic        mul_z_stb;
   logic        mul_z_ack;
   logic [31:0] res_z;
   logic        res_valid;
   logic        res_ready;
   logic        busy;
   logic        timeout_err;
   logic [15:0] jobs_done;

   int          a_dly, b_dly, z_dly;
   int          a_cnt, b_cnt, z_cnt;
   bit          ab_en, z_en, z_ovr_en;
   logic [31:0] z_ovr;
   logic [31:0] got_q [$];

   int n_checks = 0;
   int n_errors = 0;

   fp_mult_driver #(.DEPTH(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .job_a(job_a), .job_b(job_b), .job_valid(job_valid), .job_ready(job_ready),
      .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
      .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
      .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
      .res_z(res_z), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .timeout_err(timeout_err), .jobs_done(jobs_done)
   );

   always #5 clk = ~clk;

   // Operand acks, each after its own programmable delay.
   always @(posedge clk) begin
      if (rst || !mul_a_stb || mul_a_ack) begin
         mul_a_ack <= 1'b0; a_cnt <= 0;
      end else if (ab_en) begin
         if (a_cnt >= a_dly) mul_a_ack <= 1'b1; else a_cnt <= a_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (rst || !mul_b_stb || mul_b_ack) begin
         mul_b_ack <= 1'b0; b_cnt <= 0;
      end else if (ab_en) begin
         if (b_cnt >= b_dly) mul_b_ack <= 1'b1; else b_cnt <= b_cnt + 1;
      end
   end

   // Product side: z = a^b unless overridden, so the bench can predict each result.
   always @(posedge clk) begin
      if (rst) begin
         mul_z_stb <= 1'b0; mul_z <= '0; z_cnt <= 0;
      end else if (mul_z_stb) begin
         if (mul_z_ack) begin mul_z_stb <= 1'b0; z_cnt <= 0; end
      end else if (mul_z_ack && z_en) begin
         if (z_cnt >= z_dly) begin
            mul_z_stb <= 1'b1;
            mul_z     <= z_ovr_en ? z_ovr : (mul_a ^ mul_b);
         end else z_cnt <= z_cnt + 1;
      end else z_cnt <= 0;
   end

   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) got_q.push_back(res_z);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_job(input logic [31:0] a, input logic [31:0] b);
      job_a = a; job_b = b; job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [31:0] exp);
      for (int i = 0; i < 100 && got_q.size() == 0; i++) tick();
      check({tag, "_present"}, 32'(got_q.size() != 0), 32'd1);
      if (got_q.size() != 0) check(tag, got_q.pop_front(), exp);
   endtask

   initial begin
      int n;
      logic [31:0] ea, eb;
      rst = 1'b1; job_valid = 1'b0; job_a = '0; job_b = '0; res_ready = 1'b1;
      ab_en = 1'b1; z_en = 1'b1; z_ovr_en = 1'b0; z_ovr = '0;
      a_dly = 0; b_dly = 0; z_dly = 1;
      tick(); tick();
      check("rst_a_stb", 32'(mul_a_stb), 32'd0);
      check("rst_b_stb", 32'(mul_b_stb), 32'd0);
      check("rst_z_ack", 32'(mul_z_ack), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_jobs", 32'(jobs_done), 32'd0);
      check("rst_tmo", 32'(timeout_err), 32'd0);
      check("rst_ready", 32'(job_ready), 32'd1);
      check("rst_mul_a", mul_a, 32'd0);
      check("rst_res_z", res_z, 32'd0);
      rst = 1'b0;

      // 1: 2.0 * 3.0 = 6.0
      z_ovr_en = 1'b1; z_ovr = 32'h40C00000;
      push_job(32'h40000000, 32'h40400000);
      check("t1_stb_early", 32'(mul_a_stb), 32'd0);
      tick();
      check("t1_a_stb", 32'(mul_a_stb), 32'd1);
      check("t1_b_stb", 32'(mul_b_stb), 32'd1);
      check("t1_mul_a", mul_a, 32'h40000000);
      check("t1_mul_b", mul_b, 32'h40400000);
      wait_result("t1_res", 32'h40C00000);
      tick();
      check("t1_jobs", 32'(jobs_done), 32'd1);
      check("t1_idle", 32'(busy), 32'd0);
      z_ovr_en = 1'b0;

      // 2: A acked 3 cycles later than B
      a_dly = 3;
      push_job(32'h4144CCCD, 32'h4165851F);
      for (int i = 0; i < 10 && !mul_a_stb; i++) tick();
      check("t2_start", 32'(mul_a_stb), 32'd1);
      tick(); tick();
      check("t2_b_drop", 32'(mul_b_stb), 32'd0);
      check("t2_a_hold", 32'(mul_a_stb), 32'd1);
      check("t2_zack_lo1", 32'(mul_z_ack), 32'd0);
      tick(); tick();
      check("t2_a_hold3", 32'(mul_a_stb), 32'd1);
      check("t2_zack_lo3", 32'(mul_z_ack), 32'd0);
      tick();
      check("t2_a_drop", 32'(mul_a_stb), 32'd0);
      check("t2_zack_hi", 32'(mul_z_ack), 32'd1);
      wait_result("t2_res", 32'h002149D2);
      tick();
      check("t2_jobs", 32'(jobs_done), 32'd2);
      a_dly = 0;

      // 3: fill past capacity with the responder stalled
      ab_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         job_a = 32'h3F800000 + 32'(i);
         job_b = 32'h40000000 + 32'(i << 4);
         job_valid = 1'b1;
         check("t3_ready", 32'(job_ready), 32'(i < 5));
         tick();
      end
      job_valid = 1'b0;
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_head_a", mul_a, 32'h3F800000);
      check("t3_head_stb", 32'(mul_a_stb), 32'd1);
      ab_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ea = 32'h3F800000 + 32'(i);
         eb = 32'h40000000 + 32'(i << 4);
         wait_result($sformatf("t3_res%0d", i), ea ^ eb);
      end
      for (int i = 0; i < 20; i++) tick();
      check("t3_no_extra", 32'(got_q.size()), 32'd0);
      check("t3_idle", 32'(busy), 32'd0);
      check("t3_jobs", 32'(jobs_done), 32'd7);

      // 4: downstream back-pressure
      res_ready = 1'b0;
      push_job(32'h3FC00000, 32'h40100000);
      push_job(32'h40A00000, 32'h3F000000);
      for (int i = 0; i < 50 && !res_valid; i++) tick();
      for (int i = 0; i < 5; i++) begin
         check("t4_res_z", res_z, 32'h7FD00000);
         check("t4_valid", 32'(res_valid), 32'd1);
         check("t4_zack", 32'(mul_z_ack), 32'd0);
         check("t4_no_stb", 32'(mul_a_stb | mul_b_stb), 32'd0);
         tick();
      end
      res_ready = 1'b1;
      wait_result("t4_res0", 32'h7FD00000);
      wait_result("t4_res1", 32'h7FA00000);
      tick();
      check("t4_jobs", 32'(jobs_done), 32'd9);

      // 5: watchdog abort, queued job still runs
      z_en = 1'b0;
      push_job(32'h41200000, 32'h41300000);
      push_job(32'h40800000, 32'h40000000);
      for (int i = 0; i < 50 && !mul_z_ack; i++) tick();
      check("t5_tmo_pre", 32'(timeout_err), 32'd0);
      n = 0;
      while (mul_z_ack && n < 40) begin n++; tick(); end
      check("t5_wait_len", 32'(n), 32'd8);
      check("t5_tmo", 32'(timeout_err), 32'd1);
      check("t5_jobs_hold", 32'(jobs_done), 32'd9);
      tick();
      check("t5_next_stb", 32'(mul_a_stb), 32'd1);
      check("t5_next_a", mul_a, 32'h40800000);
      z_en = 1'b1;
      wait_result("t5_res", 32'h00800000);
      tick();
      check("t5_jobs", 32'(jobs_done), 32'd10);
      check("t5_tmo_sticky", 32'(timeout_err), 32'd1);

      // 6: reset while both operand strobes are up
      ab_en = 1'b0;
      push_job(32'h11111111, 32'h22222222);
      push_job(32'h33333333, 32'h44444444);
      push_job(32'h55555555, 32'h66666666);
      for (int i = 0; i < 10 && !(mul_a_stb && mul_b_stb); i++) tick();
      check("t6_in_send", 32'(mul_a_stb & mul_b_stb), 32'd1);
      rst = 1'b1;
      tick();
      check("t6_a_stb", 32'(mul_a_stb), 32'd0);
      check("t6_b_stb", 32'(mul_b_stb), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_jobs", 32'(jobs_done), 32'd0);
      check("t6_tmo", 32'(timeout_err), 32'd0);
      check("t6_ready", 32'(job_ready), 32'd1);
      check("t6_mul_a", mul_a, 32'd0);
      rst = 1'b0;
      ab_en = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("t6_fifo_empty", 32'(mul_a_stb | busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
